note_lane_renderer: RTL and testbench
=====================================

Name: note_lane_renderer

Overview:
- Downstream consumer of one lane's double-buffered note position (the 8-bit `y` produced per lane).
- Redraws that lane's note block into the 160x120, 3-bit-colour VGA adapter framebuffer: erases the old rectangle, then draws the new one, one pixel per clock.
- Seven instances (one per lane) sit behind a round-robin plot arbiter outside this block.

Parameters:
- LANE_X, 8'd10: left x pixel of this lane's note column.
- NOTE_W, 5'd16: note width in pixels (1..31).
- NOTE_H, 4'd4: note height in pixels (1..15).
- NOTE_COLOUR, 3'b110: draw colour.
- BG_COLOUR, 3'b000: erase colour.
- HIT_ROW, 7'd100: first row of the hit zone. Used only with HIT_ZONE_EN.

Ports:
- clk  in  1  system clock (50 MHz).
- resetn  in  1  asynchronous active-low reset.
- note_y  in  8  note top row from the lane's double buffer; 0 = no note present.
- enable  in  1  renderer may start a new redraw.
- vga_x  out  8  pixel x to VGA adapter.
- vga_y  out  7  pixel y to VGA adapter.
- vga_colour  out  3  pixel colour.
- plot  out  1  write strobe; the pixel is valid in the same cycle.
- busy  out  1  a redraw is in progress.
- done  out  1  one-cycle pulse after the last pixel of a redraw.

Behaviour:
- Reset (async, resetn=0): state=IDLE, vga_x=0, vga_y=0, vga_colour=0, plot=0, busy=0, done=0, drawn_y=0, cx=cy=0. Reset mid-redraw aborts immediately; partially drawn pixels are left in the framebuffer.
- FSM states: IDLE, ERASE, DRAW, FIN.
- IDLE:
  - If enable=1 and note_y != drawn_y: latch tgt_y=note_y, set busy=1, clear cx/cy.
  - Next state is ERASE if drawn_y != 0, else DRAW (skip erase). If that DRAW would itself be empty (tgt_y=0), go to FIN.
- ERASE:
  - Each cycle plot one pixel at (LANE_X+cx, drawn_y+cy) with BG_COLOUR.
  - cx counts 0..NOTE_W-1; on wrap, cy increments 0..NOTE_H-1.
  - After the pixel (NOTE_W-1, NOTE_H-1): if tgt_y != 0 go to DRAW with counters cleared, else go to FIN.
- DRAW:
  - Same scan order at (LANE_X+cx, tgt_y+cy) with NOTE_COLOUR.
  - After the last pixel, go to FIN.
- FIN: done=1 for one cycle, drawn_y<=tgt_y, busy=0, then IDLE.
- Outputs are registered. plot is asserted in the same cycle as its x/y/colour, one cycle after the counter value that produced it. A redraw of NOTE_W*NOTE_H pixels therefore takes W*H (+W*H for erase) +2 cycles from leaving IDLE.
- Clipping:
  - Row sums are computed 9 bits wide. Any pixel with row >= 120 or column >= 160 is skipped (plot=0), but still consumes its cycle.
  - note_y in 120..255 clips fully: nothing is plotted, and drawn_y still updates.
- note_y changes while busy are ignored; the value is re-compared in IDLE after FIN, so only the latest position is ever drawn.
- enable=0 in IDLE holds the block in IDLE. Deasserting enable mid-redraw has no effect; the redraw completes.
- note_y == drawn_y: no redraw, plot stays 0.

Optional Feature:
- HIT_ZONE_EN:
  - When defined, DRAW uses colour 3'b111 for any pixel whose row is >= HIT_ROW and < HIT_ROW+NOTE_H. Other pixels use NOTE_COLOUR.
  - When undefined, every DRAW pixel uses NOTE_COLOUR and HIT_ROW is unused.
  - ERASE is unaffected in both cases.

Decomposition:
- Shared package holds the screen constants SCREEN_W=160 and SCREEN_H=120, the colour constants, and the FSM state encoding (2-bit).
- One sub-module, rect_scanner: cx/cy counters with start/last outputs and size inputs, reused by ERASE and DRAW.

Test Plan:
- Reset, then note_y=20, enable=1, defaults → 64 plots at x 10..25, y 20..23, colour 110, no erase phase; done pulses at cycle 66; drawn_y=20.
- From drawn_y=20, set note_y=21 → 64 BG plots at rows 20..23, then 64 plots at rows 21..24; done at cycle 130.
- note_y=118 with NOTE_H=4 → only rows 118..119 are plotted (32 plots), plus erase of the previous note; note_y=200 → zero draw plots, drawn_y=200.
- note_y toggles 30→31→32 while busy → only the draw at 30 completes; a second redraw then erases 30 and draws 32; row 31 is never plotted.
- Assert resetn=0 mid-DRAW (pixel 17) → plot/busy drop in the same cycle with no clock edge; after release, note_y=20 redraws without an erase.
- HIT_ZONE_EN defined, HIT_ROW=100, note_y=99 → row 99 plotted in 110; rows 100..102 plotted in 111.

Source files
------------

// File: rtl/note_lane_renderer_pkg.sv
// Shared screen geometry, colour constants and renderer FSM encoding.
package note_lane_renderer_pkg;
  localparam logic [8:0] SCREEN_W = 9'd160;
  localparam logic [8:0] SCREEN_H = 9'd120;

  localparam logic [2:0] COLOUR_NOTE_DEF = 3'b110;
  localparam logic [2:0] COLOUR_BG_DEF   = 3'b000;
  localparam logic [2:0] COLOUR_HIT      = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ERASE = 2'd1,
    ST_DRAW  = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  function automatic logic on_screen(input logic [8:0] col, input logic [8:0] row);
    return (col < SCREEN_W) && (row < SCREEN_H);
  endfunction
endpackage

// File: rtl/note_lane_renderer_rect_scanner.sv
// Raster counter for a W x H rectangle: cx runs fastest, cy steps on cx wrap.
module note_lane_renderer_rect_scanner #(
  parameter int XW = 5,
  parameter int YW = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          i_start,
  input  logic          i_step,
  input  logic [XW-1:0] i_w,
  input  logic [YW-1:0] i_h,
  output logic [XW-1:0] o_cx,
  output logic [YW-1:0] o_cy,
  output logic          o_last
);
  logic [XW-1:0] r_cx;
  logic [YW-1:0] r_cy;
  logic          w_x_last;
  logic          w_y_last;

  assign w_x_last = (r_cx == i_w - XW'(1));
  assign w_y_last = (r_cy == i_h - YW'(1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cx <= '0;
      r_cy <= '0;
    end else if (i_start) begin
      r_cx <= '0;
      r_cy <= '0;
    end else if (i_step) begin
      if (w_x_last) begin
        r_cx <= '0;
        r_cy <= w_y_last ? '0 : r_cy + YW'(1);
      end else begin
        r_cx <= r_cx + XW'(1);
      end
    end
  end

  assign o_cx   = r_cx;
  assign o_cy   = r_cy;
  assign o_last = w_x_last && w_y_last;
endmodule

// File: rtl/note_lane_renderer.sv
// Per-lane note redraw: erase old block, draw new one, one registered pixel per clock.
// Optional HIT_ZONE_EN: DRAW pixels inside the hit-zone rows use the hit colour.
module note_lane_renderer
  import note_lane_renderer_pkg::*;
#(
  parameter logic [7:0] LANE_X      = 8'd10,
  parameter logic [4:0] NOTE_W      = 5'd16,
  parameter logic [3:0] NOTE_H      = 4'd4,
  parameter logic [2:0] NOTE_COLOUR = COLOUR_NOTE_DEF,
  parameter logic [2:0] BG_COLOUR   = COLOUR_BG_DEF,
  parameter logic [6:0] HIT_ROW     = 7'd100
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] note_y,
  input  logic       enable,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);
`ifdef HIT_ZONE_EN
  localparam bit HIT_EN = 1'b1;
`else
  localparam bit HIT_EN = 1'b0;
`endif

  state_t     r_state, w_next;
  logic [7:0] r_tgt_y, r_drawn_y;
  logic [7:0] r_x;
  logic [6:0] r_y;
  logic [2:0] r_colour;
  logic       r_plot, r_busy, r_done;

  logic [4:0] w_cx;
  logic [3:0] w_cy;
  logic       w_last, w_launch, w_scan;
  logic [7:0] w_base;
  logic [8:0] w_row, w_col;
  logic       w_pix_vld, w_in_hit;
  logic [2:0] w_colour;

  assign w_launch = (r_state == ST_IDLE) && enable && (note_y != r_drawn_y);
  assign w_scan   = (r_state == ST_ERASE) || (r_state == ST_DRAW);

  note_lane_renderer_rect_scanner #(.XW(5), .YW(4)) u_scan (
    .clk    (clk),
    .resetn (resetn),
    .i_start(w_launch),
    .i_step (w_scan),
    .i_w    (NOTE_W),
    .i_h    (NOTE_H),
    .o_cx   (w_cx),
    .o_cy   (w_cy),
    .o_last (w_last)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_launch) begin
          if (r_drawn_y != 8'd0)  w_next = ST_ERASE;
          else if (note_y != 8'd0) w_next = ST_DRAW;
          else                     w_next = ST_FIN;
        end
      end
      ST_ERASE: if (w_last) w_next = (r_tgt_y != 8'd0) ? ST_DRAW : ST_FIN;
      ST_DRAW:  if (w_last) w_next = ST_FIN;
      ST_FIN:   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Sums are 9 bits so off-screen pixels are detected rather than wrapped.
  always_comb begin
    w_base    = (r_state == ST_ERASE) ? r_drawn_y : r_tgt_y;
    w_row     = {1'b0, w_base} + {5'd0, w_cy};
    w_col     = {1'b0, LANE_X} + {4'd0, w_cx};
    w_pix_vld = w_scan && on_screen(w_col, w_row);
    w_in_hit  = (w_row >= {2'b00, HIT_ROW}) &&
                (w_row < ({2'b00, HIT_ROW} + {5'd0, NOTE_H}));
    w_colour  = NOTE_COLOUR;
    if (r_state == ST_ERASE)      w_colour = BG_COLOUR;
    else if (HIT_EN && w_in_hit)  w_colour = COLOUR_HIT;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_x       <= '0;
      r_y       <= '0;
      r_colour  <= '0;
      r_plot    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_tgt_y   <= '0;
      r_drawn_y <= '0;
    end else begin
      r_plot <= w_pix_vld;
      r_done <= (r_state == ST_FIN);
      if (w_pix_vld) begin
        r_x      <= w_col[7:0];
        r_y      <= w_row[6:0];
        r_colour <= w_colour;
      end
      if (w_launch) begin
        r_tgt_y <= note_y;
        r_busy  <= 1'b1;
      end
      if (r_state == ST_FIN) begin
        r_drawn_y <= r_tgt_y;
        r_busy    <= 1'b0;
      end
    end
  end

  assign vga_x      = r_x;
  assign vga_y      = r_y;
  assign vga_colour = r_colour;
  assign plot       = r_plot;
  assign busy       = r_busy;
  assign done       = r_done;
endmodule

// File: tb/tb_note_lane_renderer.sv
// Bench for note_lane_renderer: pixel-list model of each redraw checked on every plot.
module tb_note_lane_renderer;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] note_y = 8'd0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot, busy, done;

  always #10 clk = ~clk;

  note_lane_renderer dut (
    .clk(clk), .resetn(resetn), .note_y(note_y), .enable(enable),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .plot(plot), .busy(busy), .done(done)
  );

`ifdef HIT_ZONE_EN
  localparam bit HIT = 1'b1;
`else
  localparam bit HIT = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t       exp_q[$];
  int         errors = 0, checks = 0, plots_seen = 0, hit_seen = 0;
  logic [7:0] m_drawn = 8'd0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Screen-level model: every pixel of a 16x4 block at column 10, clipped to 160x120.
  function automatic void push_rect(input logic [7:0] top, input bit is_draw);
    int   row, col;
    pix_t p;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 16; c++) begin
        row = int'(top) + r;
        col = 10 + c;
        if (row < 120 && col < 160) begin
          p.x = 8'(col);
          p.y = 7'(row);
          if (!is_draw)                            p.c = 3'b000;
          else if (HIT && row >= 100 && row < 104) p.c = 3'b111;
          else                                     p.c = 3'b110;
          exp_q.push_back(p);
        end
      end
    end
  endfunction

  function automatic void model_redraw(input logic [7:0] ny);
    if (m_drawn != 8'd0) push_rect(m_drawn, 1'b0);
    if (ny != 8'd0)      push_rect(ny, 1'b1);
    m_drawn = ny;
  endfunction

  always @(negedge clk) begin
    pix_t p;
    if (resetn && plot) begin
      plots_seen++;
      if (vga_colour == 3'b111) hit_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_plot", 1, 0);
      end else begin
        p = exp_q.pop_front();
        check("pixel_x", vga_x, p.x);
        check("pixel_y", vga_y, p.y);
        check("pixel_colour", vga_colour, p.c);
      end
    end
  end

  task automatic wait_done(input int start, output int n);
    n = start;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!done && n < 400);
    if (!done) check("done_timeout", 0, 1);
  endtask

  // Called at a negedge; n counts edges from the launch edge to done visible.
  task automatic redraw(input logic [7:0] ny, input string tag,
                        input int exp_cycles, input int exp_plots);
    int n, p0;
    p0     = plots_seen;
    note_y = ny;
    enable = 1'b1;
    model_redraw(ny);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_busy"}, busy, 1);
    wait_done(1, n);
    check({tag, "_cycles"}, n, exp_cycles);
    check({tag, "_plots"}, plots_seen - p0, exp_plots);
    check({tag, "_queue_left"}, exp_q.size(), 0);
    check({tag, "_busy_at_done"}, busy, 0);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int n, p0, k, h0;

    #5;
    check("rst_vga_x", vga_x, 0);
    check("rst_vga_y", vga_y, 0);
    check("rst_colour", vga_colour, 0);
    check("rst_plot", plot, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    redraw(8'd20, "first_draw", 66, 64);
    redraw(8'd21, "move_down", 130, 128);
    redraw(8'd118, "bottom_clip", 130, 96);
    redraw(8'd200, "full_clip", 130, 32);

    p0 = plots_seen;
    repeat (10) @(negedge clk);
    check("no_change_plots", plots_seen - p0, 0);
    check("no_change_busy", busy, 0);

    // Position changes while busy must be ignored; only 30 then 32 are drawn.
    p0     = plots_seen;
    note_y = 8'd30;
    model_redraw(8'd30);
    repeat (5) @(negedge clk);
    note_y = 8'd31;
    repeat (5) @(negedge clk);
    note_y = 8'd32;
    model_redraw(8'd32);
    wait_done(10, n);
    check("toggle_first_cycles", n, 130);
    check("toggle_first_plots", plots_seen - p0, 64);
    wait_done(0, n);
    check("toggle_second_cycles", n, 130);
    check("toggle_total_plots", plots_seen - p0, 192);
    check("toggle_queue_left", exp_q.size(), 0);

    p0     = plots_seen;
    enable = 1'b0;
    note_y = 8'd50;
    repeat (10) @(negedge clk);
    check("disabled_busy", busy, 0);
    check("disabled_plots", plots_seen - p0, 0);

    // Abort with reset part-way into the DRAW phase (erase is 64 plots).
    enable = 1'b1;
    model_redraw(8'd50);
    k = 0;
    while ((plots_seen - p0) < 81 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("mid_draw_reached", (plots_seen - p0) >= 81, 1);
    #3 resetn = 1'b0;
    #1;
    check("abort_plot", plot, 0);
    check("abort_busy", busy, 0);
    check("abort_vga_x", vga_x, 0);
    exp_q.delete();
    m_drawn = 8'd0;
    @(negedge clk);
    resetn = 1'b1;
    redraw(8'd20, "after_reset", 66, 64);

    h0 = hit_seen;
    redraw(8'd99, "hit_zone", 130, 128);
    check("hit_colour_plots", hit_seen - h0, HIT ? 48 : 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
